// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams paired x/h samples into an external registered MAC,
// flushes its two-stage pipeline, then rounds and saturates the accumulator into y_data.
module dot_product_ctrl #(
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned BWIDTH = 16,
    parameter int unsigned CWIDTH = 32,
    parameter int unsigned PWIDTH = 33,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned SHIFT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic [AWIDTH-1:0] x_data,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [BWIDTH-1:0] h_data,
    input  logic              h_valid,
    output logic              h_ready,
    output logic [AWIDTH-1:0] mac_a,
    output logic [BWIDTH-1:0] mac_b,
    output logic [CWIDTH-1:0] mac_c,
    output logic              mac_ce,
    output logic              mac_rst,
    input  logic [PWIDTH-1:0] mac_p,
    output logic [OWIDTH-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready
);

    localparam int unsigned RW = PWIDTH + 1;
    localparam logic signed [RW-1:0] RND_BIAS = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] Y_MAX    = (RW'(1) << (OWIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] Y_MIN    = RW'(0) - (RW'(1) << (OWIDTH - 1));

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH1,
        FLUSH2,
        CAPTURE,
        OUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic              accept;
    logic              last_pair;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] rnd_val;
    logic [OWIDTH-1:0] sat_val;

    assign last_pair = (cnt == len_q - LEN_W'(1));
    assign mac_rst   = rst | (state == CLEAR);
    assign mac_c     = '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/MAC control; everything idles while rst is held
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        y_valid    = 1'b0;
        x_ready    = 1'b0;
        h_ready    = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        mac_ce     = 1'b0;
        accept     = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = (len != '0) ? CLEAR : OUT;
                    end
                end
                CLEAR: state_next = FEED;
                FEED: begin
                    // Each side is ready only when the other side has data, so pairs stay aligned
                    x_ready = h_valid;
                    h_ready = x_valid;
                    if (x_valid && h_valid) begin
                        accept = 1'b1;
                        mac_a  = x_data;
                        mac_b  = h_data;
                        mac_ce = 1'b1;
                        if (last_pair) begin
                            state_next = FLUSH1;
                        end
                    end
                end
                FLUSH1: begin
                    mac_ce     = 1'b1;
                    state_next = FLUSH2;
                end
                FLUSH2: begin
                    mac_ce     = 1'b1;
                    state_next = CAPTURE;
                end
                CAPTURE: state_next = OUT;
                OUT: begin
                    y_valid = 1'b1;
                    if (y_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Round half-up in one extra bit so the bias cannot wrap, then clamp to the output range
    always_comb begin
        rnd_sum = $signed({mac_p[PWIDTH-1], mac_p}) + RND_BIAS;
        rnd_val = rnd_sum >>> SHIFT;
        if (rnd_val > Y_MAX) begin
            sat_val = Y_MAX[OWIDTH-1:0];
        end else if (rnd_val < Y_MIN) begin
            sat_val = Y_MIN[OWIDTH-1:0];
        end else begin
            sat_val = rnd_val[OWIDTH-1:0];
        end
    end

    // Length latch, pair counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            cnt    <= '0;
            y_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        if (len == '0) begin
                            y_data <= '0;
                        end
                    end
                end
                CLEAR:   cnt <= '0;
                FEED: begin
                    if (accept) begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                CAPTURE: y_data <= sat_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl with a behavioural two-stage MAC and
// an arithmetic reference model of the rounded, saturated dot product.
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic [15:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] h_data;
    logic        h_valid;
    logic        h_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [31:0] mac_c;
    logic        mac_ce;
    logic        mac_rst;
    logic [32:0] mac_p;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready;

    int total = 0;
    int bad   = 0;

    int vx [256];
    int vh [256];

    int r_y, r_lat, r_pairs, r_ce;
    bit r_stable, r_pulse, r_done, r_c_ok;

    always #5 clk = ~clk;

    dot_product_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .h_data(h_data), .h_valid(h_valid), .h_ready(h_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_ce(mac_ce),
        .mac_rst(mac_rst), .mac_p(mac_p),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
    );

    // External MAC: product register then accumulator, both advance only on ce
    logic signed [31:0] mac_m;
    logic signed [32:0] mac_acc;
    always @(posedge clk) begin
        if (mac_rst) begin
            mac_m   <= '0;
            mac_acc <= '0;
        end else if (mac_ce) begin
            mac_m   <= $signed(mac_a) * $signed(mac_b) + $signed(mac_c);
            mac_acc <= mac_acc + 33'(mac_m);
        end
    end
    assign mac_p = mac_acc;

    int acc_cnt = 0;
    int ce_cnt  = 0;
    always @(posedge clk) begin
        if (x_valid && x_ready && h_valid && h_ready) acc_cnt <= acc_cnt + 1;
        if (mac_ce) ce_cnt <= ce_cnt + 1;
    end

    function automatic int ref_dot(input int n);
        longint s = 0;
        longint r;
        for (int i = 0; i < n; i++) s += longint'(vx[i]) * longint'(vh[i]);
        s = (s <<< 31) >>> 31;
        r = (s + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: start in cycle 0, optional stall windows or random valids,
    // y_ready held low for yr_hold cycles after y_valid rises, optional stray start.
    task automatic do_run(input int n, input int xs_at, input int xs_len,
                          input int hs_at, input int hs_len, input int yr_hold,
                          input bit rnd, input int sp_at);
        int idx = 0;
        int cyc;
        int a0 = acc_cnt;
        int c0 = ce_cnt;
        bit take, hs;
        logic signed [15:0] yfirst = '0;
        r_done = 0; r_stable = 1; r_lat = -1; r_c_ok = 1;
        start = 1'b1; len = 8'(n); x_valid = 0; h_valid = 0; y_ready = 0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!r_done && cyc < 1000) begin
            start = (cyc == sp_at);
            len   = 8'd7;
            if (rnd) begin
                x_valid = (idx < n) && ($urandom_range(0, 3) != 0);
                h_valid = (idx < n) && ($urandom_range(0, 3) != 0);
            end else begin
                x_valid = (idx < n) && !(cyc >= xs_at && cyc < xs_at + xs_len);
                h_valid = (idx < n) && !(cyc >= hs_at && cyc < hs_at + hs_len);
            end
            x_data = 16'(vx[idx & 255]);
            h_data = 16'(vh[idx & 255]);
            if (y_valid) begin
                if (r_lat < 0) begin
                    r_lat  = cyc;
                    yfirst = y_data;
                end else if (y_data !== yfirst) begin
                    r_stable = 0;
                end
                y_ready = (cyc - r_lat) >= yr_hold;
            end else begin
                y_ready = 1'b0;
            end
            #1;
            if (mac_c !== 32'd0) r_c_ok = 0;
            take = x_valid && h_valid && x_ready && h_ready;
            hs   = y_valid && y_ready;
            tick();
            if (take) idx++;
            if (hs) r_done = 1;
            cyc++;
        end
        start = 0; x_valid = 0; h_valid = 0; y_ready = 0;
        r_pulse = r_done && !y_valid;
        r_y     = int'(yfirst);
        r_pairs = acc_cnt - a0;
        r_ce    = ce_cnt - c0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; len = 0; x_valid = 1; h_valid = 1; y_ready = 0;
        x_data = 0; h_data = 0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
        total++; if (y_data !== 16'd0) begin bad++; $display("FAIL reset_y_data got=%0d want=0", y_data); end
        total++; if ({x_ready, h_ready, mac_ce} !== 3'b000) begin bad++; $display("FAIL reset_ready_ce got=%b want=000", {x_ready, h_ready, mac_ce}); end
        total++; if (mac_rst !== 1'b1) begin bad++; $display("FAIL reset_mac_rst got=%b want=1", mac_rst); end
        rst = 0; x_valid = 0; h_valid = 0;
        tick();
        total++; if ({mac_a, mac_b} !== 32'd0) begin bad++; $display("FAIL idle_mac_ab got=%h want=0", {mac_a, mac_b}); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin vx[i] = 16384; vh[i] = 16384; end
        do_run(3, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 24576) begin bad++; $display("FAIL basic_y got=%0d want=24576", r_y); end
        total++; if (r_lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", r_lat); end
        total++; if (r_pulse !== 1'b1) begin bad++; $display("FAIL basic_pulse got=%b want=1", r_pulse); end
        total++; if (r_pairs !== 3) begin bad++; $display("FAIL basic_pairs got=%0d want=3", r_pairs); end
        total++; if (r_ce !== 5) begin bad++; $display("FAIL basic_ce_cycles got=%0d want=5", r_ce); end
        total++; if (r_c_ok !== 1'b1) begin bad++; $display("FAIL basic_mac_c got=%b want=1", r_c_ok); end
    endtask

    task automatic test_rounding();
        vx[0] = 1; vh[0] = 16384;
        do_run(1, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 1) begin bad++; $display("FAIL round_up got=%0d want=1", r_y); end
        total++; if (r_lat !== 6) begin bad++; $display("FAIL round_latency got=%0d want=6", r_lat); end
        vx[0] = 1; vh[0] = 16383;
        do_run(1, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 0) begin bad++; $display("FAIL round_down got=%0d want=0", r_y); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin vx[i] = 32767; vh[i] = 32767; end
        do_run(4, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 32767) begin bad++; $display("FAIL sat_pos got=%0d want=32767", r_y); end
        for (int i = 0; i < 4; i++) begin vx[i] = -32768; vh[i] = 32767; end
        do_run(4, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== -32768) begin bad++; $display("FAIL sat_neg got=%0d want=-32768", r_y); end
    endtask

    task automatic test_stalls();
        vx[0] = 16384; vx[1] = 8192;  vx[2] = -4096;
        vh[0] = 16384; vh[1] = 12288; vh[2] = 20000;
        do_run(3, 3, 2, 6, 1, 5, 0, 4);
        total++; if (r_y !== ref_dot(3)) begin bad++; $display("FAIL stall_y got=%0d want=%0d", r_y, ref_dot(3)); end
        total++; if (r_pairs !== 3) begin bad++; $display("FAIL stall_pairs got=%0d want=3", r_pairs); end
        total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL stall_y_stable got=%b want=1", r_stable); end
        total++; if (r_lat !== 11) begin bad++; $display("FAIL stall_latency got=%0d want=11", r_lat); end
        total++; if (r_done !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%b want=1", r_done); end
    endtask

    task automatic test_len_zero();
        do_run(0, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 0) begin bad++; $display("FAIL len0_y got=%0d want=0", r_y); end
        total++; if (r_lat !== 1) begin bad++; $display("FAIL len0_latency got=%0d want=1", r_lat); end
        total++; if (r_ce !== 0) begin bad++; $display("FAIL len0_ce got=%0d want=0", r_ce); end
    endtask

    task automatic test_len_max();
        for (int i = 0; i < 256; i++) begin vx[i] = 128; vh[i] = 256; end
        do_run(255, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_pairs !== 255) begin bad++; $display("FAIL len255_pairs got=%0d want=255", r_pairs); end
        total++; if (r_y !== 255) begin bad++; $display("FAIL len255_y got=%0d want=255", r_y); end
        total++; if (r_lat !== 260) begin bad++; $display("FAIL len255_latency got=%0d want=260", r_lat); end
    endtask

    task automatic test_reset_mid();
        int yv = 0;
        for (int i = 0; i < 5; i++) begin vx[i] = 3000; vh[i] = 3000; end
        start = 1; len = 8'd5;
        tick();
        start = 0; x_valid = 1; h_valid = 1; x_data = 16'd3000; h_data = 16'd3000;
        tick(); tick(); tick();
        rst = 1;
        #1;
        total++; if (mac_rst !== 1'b1) begin bad++; $display("FAIL midrst_mac_rst got=%b want=1", mac_rst); end
        tick();
        rst = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (x_ready !== 1'b0) begin bad++; $display("FAIL midrst_x_ready got=%b want=0", x_ready); end
        total++; if (y_data !== 16'd0) begin bad++; $display("FAIL midrst_y_data got=%0d want=0", y_data); end
        x_valid = 0; h_valid = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (y_valid) yv++; end
        total++; if (yv !== 0) begin bad++; $display("FAIL midrst_no_y_valid got=%0d want=0", yv); end
        vx[0] = 2; vh[0] = 16384;
        do_run(1, -1, 0, -1, 0, 0, 0, -1);
        total++; if (r_y !== 1) begin bad++; $display("FAIL midrst_next_run got=%0d want=1", r_y); end
    endtask

    task automatic test_random();
        int n;
        int exp_y;
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                vx[i] = int'($signed(16'($urandom)));
                vh[i] = int'($signed(16'($urandom)));
            end
            exp_y = ref_dot(n);
            do_run(n, -1, 0, -1, 0, $urandom_range(0, 3), 1, -1);
            total++; if (r_y !== exp_y) begin bad++; $display("FAIL random_y run=%0d n=%0d got=%0d want=%0d", t, n, r_y, exp_y); end
            total++; if (r_pairs !== n) begin bad++; $display("FAIL random_pairs run=%0d got=%0d want=%0d", t, r_pairs, n); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_stalls();
        test_len_zero();
        test_len_max();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
